sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//   Shares the single 16-bit asynchronous SRAM between two requesters: the CPU
//   memory path (port C) and the debug/loader path (port D).
//   Sequences each granted access into a fixed two-cycle strobe window.
//   Drives the active-low Mem_CE/OE/WE/UB/LB pins and the tristate data bus
//   control. Sits between the datapath MAR/MDR and the SRAM pins.
// PARAMETERS
//   ADDR_W   20   SRAM word-address width
//   DATA_W   16   SRAM data width
// PORTS
//   Clk          in   1       system clock; all logic on posedge Clk
//   Reset        in   1       synchronous, active-high reset
//   c_req        in   1       port C access request (level)
//   c_we         in   1       port C 1=write, 0=read
//   c_addr       in   ADDR_W  port C word address
//   c_wdata      in   DATA_W  port C write data
//   c_rdata      out  DATA_W  port C read data; valid when c_ack=1
//   c_ack        out  1       port C one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack   same as port C, for port D
//   sram_addr    out  ADDR_W  SRAM address pins
//   sram_dq_out  out  DATA_W  data driven to SRAM
//   sram_dq_oe   out  1       1=FPGA drives DQ bus (writes only)
//   sram_dq_in   in   DATA_W  data read from SRAM
//   Mem_CE/Mem_OE/Mem_WE/Mem_UB/Mem_LB  out 1 each  active-low SRAM strobes
//   grant_d      out  1       1 while the current or last transaction belongs to D
// BEHAVIOUR
//   Reset (at the next posedge while Reset=1): state=IDLE; Mem_CE/OE/WE/UB/LB=1;
//     sram_dq_oe=0; acks=0; rdata regs=0; sram_addr=0; grant_d=0.
//     Reset mid-access aborts it. Strobes deassert at that same edge. No ack issued.
//   FSM states: IDLE -> ACC1 -> ACC2 -> RCVR -> IDLE.
//   IDLE: if any req=1, pick a winner. Latch winner's addr/we/wdata into internal
//     regs, drive sram_addr from these regs, and go to ACC1.
//     Requester changes after the grant edge are ignored.
//   ACC1: CE=UB=LB=0. On read, OE=0 and WE=1. On write, WE=0, OE=1, dq_oe=1.
//   ACC2: same strobes as ACC1. On read, capture sram_dq_in into the winner's
//     rdata reg at the edge leaving ACC2.
//   RCVR: all strobes=1, dq_oe=0 (bus turnaround). Winner's ack=1 for exactly
//     this cycle. Its rdata holds the read value from this cycle until its next
//     read completes. Writes leave rdata unchanged.
//   Requester deasserts req at the edge sampling ack=1. A req still high in IDLE
//     starts a new transaction.
//   Latency: grant edge to ack is 3 cycles. Back-to-back throughput is one access
//     per 4 cycles.
//   Loser's req is held pending. The loser never receives an ack.
//   sram_dq_oe is never 1 while Mem_OE=0. Mem_WE and Mem_OE are never both 0.
//   c_ack and d_ack are never both 1.
//   Arbitration on simultaneous requests: see CONFIGURATION.
//   A req arriving during ACC1/ACC2/RCVR is evaluated in the next IDLE.
// CONFIGURATION
//   SRAM_ARB_ROUND_ROBIN_EN defined: a last-winner flag (reset to D, so C wins
//     first) grants the port that did not win last when both request in IDLE.
//     A lone requester always wins.
//   Undefined: fixed priority, C always beats D. D may starve while C streams.
//     This is the intended behaviour.
// TESTING
//   1. Write then read. C writes 0xBEEF @0x00012, then reads @0x00012.
//      -> WE low exactly 2 cycles, c_ack on the 4th cycle, c_rdata=0xBEEF.
//   2. Simultaneous requests. c_req=d_req=1 in the same cycle.
//      -> C is served first and D next.
//      -> With ROUND_ROBIN_EN and both held: order C,D,C,D.
//      -> Without: C,C,C while c_req stays high.
//   3. Input change after grant. Change c_addr from 0x00100 to 0x00200 one cycle
//      after the grant. -> sram_addr stays 0x00100 until RCVR.
//   4. Reset mid-access. Assert Reset during ACC2 of a write.
//      -> All strobes=1 and dq_oe=0 after that edge; no ack; state IDLE.
//   5. Back-to-back reads. d_req held high for reads @0x0,0x1,0x2 with SRAM model
//      data 0x1111/0x2222/0x3333.
//      -> d_ack every 4 cycles with the matching d_rdata.
//   6. Bus-contention assertion throughout all runs: never
//      (dq_oe & ~Mem_OE), never (~Mem_WE & ~Mem_OE), never (c_ack & d_ack).

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async 16-bit SRAM between CPU port C and debug port D using a fixed 4-cycle access.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating arbitration; default build gives port C fixed priority.
module sram_port_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              grant_d
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RCVR} state_t;

    state_t            state_q, state_d;
    logic              win_d_q, we_q, pick_d, grant, access;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, c_rdata_q, d_rdata_q;

    assign grant = (state_q == IDLE) && (c_req || d_req);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_d_q;
    // Starts at D so that C wins the first contested grant.
    assign pick_d = d_req && (!c_req || !last_d_q);
    always_ff @(posedge Clk) begin
        if (Reset) last_d_q <= 1'b1;
        else if (grant) last_d_q <= pick_d;
    end
`else
    assign pick_d = d_req && !c_req;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant ? ACC1 : IDLE;
            ACC1:    state_d = ACC2;
            ACC2:    state_d = RCVR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            win_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (grant) begin
                win_d_q <= pick_d;
                we_q    <= pick_d ? d_we : c_we;
                addr_q  <= pick_d ? d_addr : c_addr;
                wdata_q <= pick_d ? d_wdata : c_wdata;
            end
            if (state_q == ACC2 && !we_q && !win_d_q) c_rdata_q <= sram_dq_in;
            if (state_q == ACC2 && !we_q && win_d_q) d_rdata_q <= sram_dq_in;
        end
    end

    // RCVR keeps every strobe high so the DQ bus turns around before the next access.
    always_comb begin
        access     = (state_q == ACC1) || (state_q == ACC2);
        Mem_CE     = !access;
        Mem_UB     = !access;
        Mem_LB     = !access;
        Mem_OE     = !(access && !we_q);
        Mem_WE     = !(access && we_q);
        sram_dq_oe = access && we_q;
        c_ack      = (state_q == RCVR) && !win_d_q;
        d_ack      = (state_q == RCVR) && win_d_q;
    end

    assign sram_addr   = addr_q;
    assign sram_dq_out = wdata_q;
    assign grant_d     = win_d_q;
    assign c_rdata     = c_rdata_q;
    assign d_rdata     = d_rdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of sram_port_arbiter against a behavioural SRAM.
module tb_sram_port_arbiter;
    logic        Clk, Reset;
    logic        c_req, c_we, c_ack, d_req, d_we, d_ack;
    logic [19:0] c_addr, d_addr, sram_addr;
    logic [15:0] c_wdata, c_rdata, d_wdata, d_rdata, sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, grant_d;
    logic [15:0] mem [0:1023];
    int          n_cmp = 0, n_err = 0;

    sram_port_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .grant_d(grant_d)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign sram_dq_in = mem[sram_addr[9:0]];

    always @(posedge Clk) begin
        if (Reset) begin
            mem[0]     <= 16'h1111;
            mem[1]     <= 16'h2222;
            mem[2]     <= 16'h3333;
            mem[10'h100] <= 16'hA5A5;
            mem[10'h200] <= 16'h5A5A;
        end else if (!Mem_CE && !Mem_WE) begin
            mem[sram_addr[9:0]] <= sram_dq_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("dq_oe_while_oe", {31'b0, sram_dq_oe & ~Mem_OE}, 0);
            chk("we_and_oe_low", {31'b0, ~Mem_WE & ~Mem_OE}, 0);
            chk("both_acks", {31'b0, c_ack & d_ack}, 0);
        end
    end

    // Call at posedge+#1; returns the cycle of the ack (0 if none) and WE-low cycles seen.
    task automatic access(input logic port_d, input logic we, input logic [19:0] addr, input logic [15:0] wd,
                          output int ack_cyc, output int we_low, output logic [15:0] rd);
        ack_cyc = 0;
        we_low  = 0;
        rd      = '0;
        if (port_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd;
        end
        for (int i = 1; i <= 10 && ack_cyc == 0; i++) begin
            @(negedge Clk);
            if (!Mem_WE) we_low++;
            if (port_d ? d_ack : c_ack) begin
                ack_cyc = i;
                rd = port_d ? d_rdata : c_rdata;
            end
        end
        @(posedge Clk);
        #1;
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ack_cyc, we_low, nack, found;
        logic [15:0] rd;
        logic [3:0]  seq, exp_seq;
        Reset = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_strobes", {27'b0, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}, 32'h1f);
        chk("rst_dq_oe", {31'b0, sram_dq_oe}, 0);
        chk("rst_acks", {30'b0, c_ack, d_ack}, 0);
        chk("rst_rdata", {c_rdata, d_rdata}, 0);
        chk("rst_addr", {12'b0, sram_addr}, 0);
        chk("rst_grant_d", {31'b0, grant_d}, 0);
        Reset = 1'b0;

        access(1'b0, 1'b1, 20'h00012, 16'hBEEF, ack_cyc, we_low, rd);
        chk("wr_ack_cycle", ack_cyc, 4);
        chk("wr_we_low", we_low, 2);
        access(1'b0, 1'b0, 20'h00012, 16'h0000, ack_cyc, we_low, rd);
        chk("rd_ack_cycle", ack_cyc, 4);
        chk("rd_we_low", we_low, 0);
        chk("rd_data", {16'b0, rd}, 32'hBEEF);

        c_req = 1; c_we = 0; c_addr = 20'h00001;
        d_req = 1; d_we = 0; d_addr = 20'h00002;
        seq = 0; nack = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge Clk);
            if (c_ack || d_ack) begin
                seq = {seq[2:0], d_ack};
                nack++;
            end
        end
        @(posedge Clk);
        #1;
        c_req = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b0000;
`endif
        chk("arb_order", {28'b0, seq}, {28'b0, exp_seq});
        chk("arb_acks", nack, 4);
        found = 0;
        for (int i = 1; i <= 8 && found == 0; i++) begin
            @(negedge Clk);
            if (d_ack) begin
                found = i;
                rd = d_rdata;
            end
        end
        chk("d_after_c", found, 4);
        chk("d_after_c_data", {16'b0, rd}, 32'h3333);
        @(posedge Clk);
        #1;
        d_req = 0;

        c_req = 1; c_we = 0; c_addr = 20'h00100;
        @(posedge Clk);
        #1;
        c_addr = 20'h00200;
        @(negedge Clk);
        chk("hold_addr_acc1", {12'b0, sram_addr}, 32'h00100);
        @(negedge Clk);
        chk("hold_addr_acc2", {12'b0, sram_addr}, 32'h00100);
        @(negedge Clk);
        chk("hold_ack", {31'b0, c_ack}, 1);
        chk("hold_data", {16'b0, c_rdata}, 32'hA5A5);
        @(posedge Clk);
        #1;
        c_req = 0;

        d_req = 1; d_we = 0; d_addr = 20'h00000;
        for (int k = 0; k < 3; k++) begin
            found = 0;
            for (int i = 1; i <= 8 && found == 0; i++) begin
                @(negedge Clk);
                if (d_ack) begin
                    found = i;
                    rd = d_rdata;
                end
            end
            chk($sformatf("b2b_period_%0d", k), found, 4);
            chk($sformatf("b2b_data_%0d", k), {16'b0, rd}, 32'h1111 * (k + 1));
            @(posedge Clk);
            #1;
            d_addr = 20'(k + 1);
        end
        d_req = 0;

        c_req = 1; c_we = 1; c_addr = 20'h00300; c_wdata = 16'h5555;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        c_req = 0;
        Reset = 1;
        @(negedge Clk);
        chk("acc2_we_low", {31'b0, Mem_WE}, 0);
        @(posedge Clk);
        #1;
        Reset = 0;
        @(negedge Clk);
        chk("abort_strobes", {27'b0, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB}, 32'h1f);
        chk("abort_dq_oe", {31'b0, sram_dq_oe}, 0);
        chk("abort_grant_d", {31'b0, grant_d}, 0);
        chk("abort_addr", {12'b0, sram_addr}, 0);
        chk("abort_rdata", {c_rdata, d_rdata}, 0);
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (c_ack || d_ack) nack++;
        end
        chk("abort_no_ack", nack, 0);
        @(posedge Clk);
        #1;
        access(1'b0, 1'b0, 20'h00100, 16'h0000, ack_cyc, we_low, rd);
        chk("post_rst_cycle", ack_cyc, 4);
        chk("post_rst_data", {16'b0, rd}, 32'hA5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
